lsu_mem_ctrl: RTL and testbench

//  Load/store initiator between the core's MEM stage and the data-RAM port.

---
 rtl/lsu_mem_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core MEM stage and the data-RAM port.
// One transaction at a time: validate, issue a word-aligned request, extend load data, respond.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t      state, state_d;
    logic        op_store;
    logic [2:0]  op_func;
    logic [1:0]  op_off;
    logic [31:0] to_cnt;
    logic        err_d;
    logic [31:0] rdata_d;
    logic        timeout_hit;
    logic        start_issue;

    function automatic logic bad_op(input logic store, input logic [2:0] func,
                                    input logic [1:0] off);
        logic bad;
        case (func)
            3'b000:  bad = 1'b0;
            3'b001:  bad = off[0];
            3'b010:  bad = (off != 2'b00);
            3'b100:  bad = store;
            3'b101:  bad = store | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] func, input logic [1:0] off);
        logic [3:0] m;
        case (func[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] func, input logic [1:0] off,
                                              input logic [31:0] d);
        logic [31:0] v;
        case (func[1:0])
            2'b00:   v = {24'b0, d[7:0]} << {off, 3'b000};
            2'b01:   v = {16'b0, d[15:0]} << {off, 3'b000};
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] func, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] w;
        logic [31:0] v;
        w = word >> {off, 3'b000};
        case (func)
            3'b000:  v = {{24{w[7]}}, w[7:0]};
            3'b100:  v = {24'b0, w[7:0]};
            3'b001:  v = {{16{w[15]}}, w[15:0]};
            3'b101:  v = {16'b0, w[15:0]};
            default: v = w;
        endcase
        return v;
    endfunction

    assign req_ready   = (state == IDLE);
    assign timeout_hit = TO_EN && (to_cnt >= TO_LAST);
    assign start_issue = (state == IDLE) && (state_d == ISSUE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // A completing handshake or rvalid is checked before the timeout so it wins on a tie.
    always_comb begin
        state_d = state;
        err_d   = 1'b0;
        rdata_d = 32'd0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_op(req_store, req_func, req_addr[1:0])) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d = op_store ? RESP : WAIT;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    rdata_d = load_extend(op_func, op_off, mem_rdata);
                end else if (timeout_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= 32'd0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            mem_wmask     <= 4'd0;
            to_cnt        <= 32'd0;
        end else begin
            resp_valid    <= (state_d == RESP);
            resp_err      <= err_d;
            resp_rdata    <= rdata_d;
            mem_req_valid <= (state_d == ISSUE);
            if (start_issue) begin
                mem_we    <= req_store;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_wmask <= req_store ? lane_mask(req_func, req_addr[1:0]) : 4'd0;
                mem_wdata <= req_store ? lane_data(req_func, req_addr[1:0], req_wdata) : 32'd0;
                to_cnt    <= 32'd0;
            end else if ((state == ISSUE || state == WAIT) && to_cnt != '1) begin
                to_cnt <= to_cnt + 32'd1;
            end
        end
    end

    // Operation descriptor needed after the core has moved on; no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            op_store <= req_store;
            op_func  <= req_func;
            op_off   <= req_addr[1:0];
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a size/offset arithmetic model.
module tb_lsu_mem_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_func;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, alignment by modulo, lanes by arithmetic shifts.
    function automatic int m_size(input logic [2:0] func);
        return 1 << func[1:0];
    endfunction

    function automatic bit m_err(input bit store, input logic [2:0] func, input logic [31:0] addr);
        if (func[1:0] == 2'b11 || func == 3'b110) return 1'b1;
        if (store && func[2]) return 1'b1;
        return (addr % m_size(func)) != 0;
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] func, input logic [31:0] addr);
        int sz  = m_size(func);
        int off = int'(addr % 4);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] func, input logic [31:0] addr,
                                            input logic [31:0] d);
        longint unsigned keep, v;
        int sz  = m_size(func);
        int off = int'(addr % 4);
        keep = (64'd1 << (8 * sz)) - 64'd1;
        v = ({32'd0, d} & keep) << (8 * off);
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] func, input logic [31:0] addr,
                                           input logic [31:0] word);
        longint unsigned w, v, lim;
        int sz   = m_size(func);
        int off  = int'(addr % 4);
        int bits = 8 * sz;
        w   = {32'd0, word} >> (8 * off);
        lim = 64'd1 << bits;
        v   = w % lim;
        if (!func[2] && sz < 4 && v >= (lim >> 1)) v = v - lim;
        return v[31:0];
    endfunction

    task automatic do_op(input bit store, input logic [2:0] func, input logic [31:0] addr,
                         input logic [31:0] d, input int rdly, input int vdly,
                         input logic [31:0] word);
        bit          e;
        logic [31:0] ea, ed;
        logic [3:0]  em;
        e  = m_err(store, func, addr);
        ea = addr & ~32'h3;
        em = store ? m_mask(func, addr) : 4'h0;
        ed = store ? m_wdata(func, addr, d) : 32'd0;
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_store = store; req_func = func; req_addr = addr; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_func = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (e) begin
            chk("err_resp_valid", 32'(resp_valid), 1);
            chk("err_resp_err", 32'(resp_err), 1);
            chk("err_rdata", resp_rdata, 0);
            chk("err_mem_req_valid", 32'(mem_req_valid), 0);
        end else begin
            for (int i = 0; i <= rdly; i++) begin
                chk("issue_valid", 32'(mem_req_valid), 1);
                chk("issue_addr", mem_addr, ea);
                chk("issue_we", 32'(mem_we), 32'(store));
                chk("issue_wmask", 32'(mem_wmask), 32'(em));
                chk("issue_wdata", mem_wdata, ed);
                chk("issue_no_resp", 32'(resp_valid), 0);
                chk("issue_ready_low", 32'(req_ready), 0);
                if (i == rdly) mem_req_ready = 1'b1;
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            chk("post_hs_valid", 32'(mem_req_valid), 0);
            if (!store) begin
                chk("wait_no_resp", 32'(resp_valid), 0);
                for (int i = 0; i < vdly; i++) begin
                    @(negedge clk);
                    chk("wait_no_resp", 32'(resp_valid), 0);
                end
                mem_rvalid = 1'b1; mem_rdata = word;
                @(negedge clk);
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
            chk("resp_valid", 32'(resp_valid), 1);
            chk("resp_err", 32'(resp_err), 0);
            chk("resp_rdata", resp_rdata, store ? 32'd0 : m_load(func, addr, word));
        end
        @(negedge clk);
        chk("resp_pulse_end", 32'(resp_valid), 0);
        chk("resp_err_idle", 32'(resp_err), 0);
        chk("rdata_idle", resp_rdata, 0);
        chk("req_ready_back", 32'(req_ready), 1);
    endtask

    logic [2:0] funcs [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_func = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wmask", 32'(mem_wmask), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed stores, loads and illegal requests
        do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        do_op(1'b1, 3'b000, 32'h103, 32'h123456A5, 0, 0, 32'h0);
        do_op(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 0, 0, 32'h0);
        do_op(1'b0, 3'b000, 32'h102, 32'h0, 0, 0, 32'h12803456);
        do_op(1'b0, 3'b100, 32'h102, 32'h0, 0, 0, 32'h12803456);
        do_op(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h12803456);
        do_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h12803456);
        do_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h12803456);
        do_op(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0);
        do_op(1'b1, 3'b001, 32'h101, 32'h1234, 0, 0, 32'h0);
        do_op(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
        do_op(1'b1, 3'b100, 32'h100, 32'h55, 0, 0, 32'h0);
        do_op(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 3, 0, 32'h0);
        do_op(1'b0, 3'b001, 32'h206, 32'h0, 3, 2, 32'h8001C0DE);

        // Load whose read data never arrives
        chk("to1_ready", 32'(req_ready), 1);
        req_valid = 1'b1; req_store = 1'b0; req_func = 3'b010; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        chk("to1_issue", 32'(mem_req_valid), 1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int c = 2; c <= TO; c++) begin
            chk("to1_quiet", 32'(resp_valid), 0);
            @(negedge clk);
        end
        chk("to1_resp_valid", 32'(resp_valid), 1);
        chk("to1_resp_err", 32'(resp_err), 1);
        chk("to1_rdata", resp_rdata, 0);
        @(negedge clk);
        chk("to1_idle", 32'(req_ready), 1);

        // Request that the memory never accepts
        req_valid = 1'b1; req_store = 1'b1; req_func = 3'b000; req_addr = 32'h301;
        req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            chk("to2_issue", 32'(mem_req_valid), 1);
            chk("to2_quiet", 32'(resp_valid), 0);
            @(negedge clk);
        end
        chk("to2_resp_valid", 32'(resp_valid), 1);
        chk("to2_resp_err", 32'(resp_err), 1);
        chk("to2_mem_req_valid", 32'(mem_req_valid), 0);
        @(negedge clk);
        chk("to2_idle", 32'(req_ready), 1);

        // Reset while waiting for read data, then a late rvalid
        req_valid = 1'b1; req_store = 1'b0; req_func = 3'b010; req_addr = 32'h300;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        chk("rstw_ready", 32'(req_ready), 1);
        chk("rstw_resp_valid", 32'(resp_valid), 0);
        chk("rstw_mem_req_valid", 32'(mem_req_valid), 0);
        chk("rstw_mem_addr", mem_addr, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rstw_late_rvalid", 32'(resp_valid), 0);
        chk("rstw_late_ready", 32'(req_ready), 1);
        do_op(1'b0, 3'b000, 32'h403, 32'h0, 1, 1, 32'h7F00FF00);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
                @(negedge clk);
                mem_rvalid = 1'b0;
                chk("idle_rvalid_ignored", 32'(resp_valid), 0);
                chk("idle_rvalid_ready", 32'(req_ready), 1);
            end
            do_op(1'($urandom_range(0, 1)), funcs[$urandom_range(0, 7)], $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
